rand_operand_gen: RTL and testbench
===================================

RAND_OPERAND_GEN -- requirements
Module: rand_operand_gen

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, meaning width of the LFSR state vector consumed.
REQ-002 SHALL have parameter OP_WIDTH, default 32, meaning width of each operand; 2*OP_WIDTH <= IN_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a run.
REQ-006 SHALL have port seed  input  16  LFSR seed for the run.
REQ-007 SHALL have port num_vectors  input  16  operand pairs to issue; sampled on start.
REQ-008 SHALL have port lfsr_resetn  output  1  synchronous load strobe (active-low) to the LFSR.
REQ-009 SHALL have port lfsr_init  output  16  seed driven to the LFSR.
REQ-010 SHALL have port lfsr_in  input  IN_WIDTH  LFSR state vector.
REQ-011 SHALL have ports op_a / op_b  output  OP_WIDTH each  operand pair.
REQ-012 SHALL have ports op_valid (output, 1) / op_ready (input, 1)  operand handshake.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).
REQ-014 SHALL have port checksum  output  OP_WIDTH  XOR accumulator (see Configuration).

Function
REQ-015 SHALL implement states IDLE, SEED, WARM, RUN, DONE.
REQ-016 IDLE: on start, latch seed and num_vectors, go SEED; busy=0 only in IDLE.
REQ-017 SEED: lasts exactly 1 cycle; lfsr_resetn=0, lfsr_init=latched seed; next WARM. lfsr_resetn=1 in all other states.
REQ-018 WARM: 1 cycle, lets LFSR present the seeded state; next RUN, or DONE if latched num_vectors==0.
REQ-019 RUN: when output register empty or (op_valid && op_ready), load op_a=lfsr_in[OP_WIDTH-1:0], op_b=lfsr_in[2*OP_WIDTH-1:OP_WIDTH], set op_valid=1, until num_vectors pairs have been loaded.
REQ-020 op_a/op_b SHALL stay stable while op_valid=1 and op_ready=0; lfsr_in changes during stall are ignored.
REQ-021 Issued counter SHALL increment per accepted handshake (op_valid && op_ready); when it reaches num_vectors, op_valid drops next cycle and state goes DONE.
REQ-022 Back-to-back throughput with op_ready held 1 SHALL be one pair per cycle; first op_valid rises the cycle after WARM.
REQ-023 DONE: done=1 for exactly 1 cycle, then IDLE.
REQ-024 start SHALL be ignored outside IDLE; start with num_vectors=0 yields SEED, WARM, DONE, no op_valid.
REQ-025 Counter SHALL be 16 bits; num_vectors=16'hFFFF issues 65535 pairs, no wrap.

Reset
REQ-026 resetn low SHALL asynchronously force IDLE, op_valid=0, op_a=op_b=0, busy=0, done=0, lfsr_resetn=1, lfsr_init=0, checksum=0, counter=0.
REQ-027 Reset mid-RUN SHALL abort the run; no done pulse; pending operand discarded.

Configuration
REQ-028 Macro RAND_OPGEN_CHECKSUM_EN defined: checksum SHALL XOR op_a^op_b into an accumulator on each accepted handshake, cleared on entering SEED, held after DONE.
REQ-029 Macro undefined: checksum SHALL be constant 0 and no accumulator logic exists.

Structure
REQ-030 Shared package versal_arith_pkg SHALL hold the state enum opgen_state_t and default constants OPGEN_IN_WIDTH=128, OPGEN_OP_WIDTH=32.
REQ-031 Output register with load/hold logic SHALL be one sub-module, opgen_out_reg; the LFSR is instantiated outside this block.

Verification
REQ-032 start, seed=16'hACE1, num_vectors=3: lfsr_resetn low exactly 1 cycle with lfsr_init=16'hACE1; busy high from next cycle.
REQ-033 lfsr_in=...0000_0002_0000_0001 in RUN, op_ready=1: op_a=32'h1, op_b=32'h2; 3 handshakes then one done pulse.
REQ-034 op_ready=0 for 5 cycles while lfsr_in changes: op_a/op_b unchanged, op_valid stays 1.
REQ-035 num_vectors=0: no op_valid, done pulses 3 cycles after start.
REQ-036 resetn asserted during RUN after 1 handshake: all outputs at reset values immediately, no done.
REQ-037 With RAND_OPGEN_CHECKSUM_EN, pairs (1,2),(4,8): checksum=32'hF; without macro: checksum=0.

Source files
------------

// File: rtl/versal_arith_pkg.sv
// Shared arithmetic-test package: operand generator state encoding and default widths.
package versal_arith_pkg;

  localparam int OPGEN_IN_WIDTH = 128;
  localparam int OPGEN_OP_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_WARM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } opgen_state_t;

endpackage

// File: rtl/opgen_out_reg.sv
// Operand output register: loads a new pair on i_load, otherwise holds; valid drops on
// an accepted handshake with no replacement load.
module opgen_out_reg
  import versal_arith_pkg::*;
#(
  parameter int OP_WIDTH = OPGEN_OP_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_load,
  input  logic                i_accept,
  input  logic [OP_WIDTH-1:0] i_a,
  input  logic [OP_WIDTH-1:0] i_b,
  output logic                o_valid,
  output logic [OP_WIDTH-1:0] o_a,
  output logic [OP_WIDTH-1:0] o_b
);

  logic                r_valid;
  logic [OP_WIDTH-1:0] r_a;
  logic [OP_WIDTH-1:0] r_b;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_a     <= i_a;
      r_b     <= i_b;
    end else if (i_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;

endmodule

// File: rtl/rand_operand_gen.sv
// Random operand pair generator: seeds an external LFSR, then streams operand pairs from
// its state over a valid/ready handshake. Optional XOR checksum under RAND_OPGEN_CHECKSUM_EN.
module rand_operand_gen
  import versal_arith_pkg::*;
#(
  parameter int IN_WIDTH = OPGEN_IN_WIDTH,
  parameter int OP_WIDTH = OPGEN_OP_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [15:0]         seed,
  input  logic [15:0]         num_vectors,
  output logic                lfsr_resetn,
  output logic [15:0]         lfsr_init,
  input  logic [IN_WIDTH-1:0] lfsr_in,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                busy,
  output logic                done,
  output logic [OP_WIDTH-1:0] checksum
);

  opgen_state_t r_state;
  logic [15:0]  r_seed;
  logic [15:0]  r_nv;
  logic [15:0]  r_issued;
  logic         r_busy;
  logic         r_done;
  logic         r_lfsr_resetn;

  logic         w_valid;
  logic         w_hs;
  logic         w_last;
  logic         w_load;
  logic [OP_WIDTH-1:0] w_op_a;
  logic [OP_WIDTH-1:0] w_op_b;

  assign w_hs   = w_valid & op_ready;
  assign w_last = (r_issued == (r_nv - 16'd1));
  // The first pair is captured at the end of WARM, so op_valid rises on the first RUN cycle.
  assign w_load = ((r_state == ST_WARM) && (r_nv != 16'd0)) ||
                  ((r_state == ST_RUN) && (!w_valid || w_hs) && !(w_hs && w_last));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_seed        <= '0;
      r_nv          <= '0;
      r_issued      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_lfsr_resetn <= 1'b1;
    end else begin
      r_done        <= 1'b0;
      r_lfsr_resetn <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_seed        <= seed;
            r_nv          <= num_vectors;
            r_issued      <= '0;
            r_busy        <= 1'b1;
            r_lfsr_resetn <= 1'b0;
            r_state       <= ST_SEED;
          end
        end
        ST_SEED: r_state <= ST_WARM;
        ST_WARM: begin
          if (r_nv == 16'd0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_issued <= r_issued + 16'd1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  opgen_out_reg #(
    .OP_WIDTH(OP_WIDTH)
  ) u_out_reg (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_load   (w_load),
    .i_accept (w_hs),
    .i_a      (lfsr_in[OP_WIDTH-1:0]),
    .i_b      (lfsr_in[2*OP_WIDTH-1:OP_WIDTH]),
    .o_valid  (w_valid),
    .o_a      (w_op_a),
    .o_b      (w_op_b)
  );

  generate
    if (IN_WIDTH > 2*OP_WIDTH) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^lfsr_in[IN_WIDTH-1:2*OP_WIDTH];
    end
  endgenerate

`ifdef RAND_OPGEN_CHECKSUM_EN
  logic [OP_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_checksum <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum ^ w_op_a ^ w_op_b;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign op_valid    = w_valid;
  assign op_a        = w_op_a;
  assign op_b        = w_op_b;
  assign busy        = r_busy;
  assign done        = r_done;
  assign lfsr_resetn = r_lfsr_resetn;
  assign lfsr_init   = r_seed;

endmodule

// File: tb/tb_rand_operand_gen.sv
// Bench for rand_operand_gen: cycle-level behavioural model plus directed scenarios.
module tb_rand_operand_gen;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [15:0]  seed;
  logic [15:0]  num_vectors;
  logic         lfsr_resetn;
  logic [15:0]  lfsr_init;
  logic [127:0] lfsr_in;
  logic [31:0]  op_a;
  logic [31:0]  op_b;
  logic         op_valid;
  logic         op_ready;
  logic         busy;
  logic         done;
  logic [31:0]  checksum;

  int n_checks = 0;
  int n_errors = 0;

  rand_operand_gen #(.IN_WIDTH(128), .OP_WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .seed        (seed),
    .num_vectors (num_vectors),
    .lfsr_resetn (lfsr_resetn),
    .lfsr_init   (lfsr_init),
    .lfsr_in     (lfsr_in),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pair(input logic [31:0] a, input logic [31:0] b);
    return {64'h0, b, a};
  endfunction

  // Model: a run starts in the cycle start is seen while idle (rel 0); SEED is rel 1,
  // WARM rel 2, pairs are offered from rel 3 until num_vectors have been accepted, and
  // done follows the final acceptance (or rel 3 for an empty run). Pair 0 is the LFSR
  // word during WARM; pair k+1 is the LFSR word during the cycle pair k was accepted.
  int          cyc = 0;
  bit          m_act = 0;
  int          m_s = 0;
  int          m_nv = 0;
  int          m_iss = 0;
  bit          m_done_next = 0;
  logic [15:0] m_seed = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_ck = '0;

  always @(negedge clk) begin
    int  rel;
    bit  e_lrn, e_busy, e_valid, e_done;
    logic [31:0] e_ck;
    cyc++;
    if (!resetn) begin
      chk("rst_valid", op_valid, 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lfsr_resetn", lfsr_resetn, 1);
      chk("rst_lfsr_init", lfsr_init, 0);
      chk("rst_checksum", checksum, 0);
      m_act = 0;
      m_done_next = 0;
      m_ck = '0;
    end else begin
      rel = m_act ? (cyc - m_s) : -1;
      if (m_act && rel == 1) m_ck = '0;
      if (m_act && rel == 2) begin
        m_a = lfsr_in[31:0];
        m_b = lfsr_in[63:32];
      end
      e_lrn   = !(m_act && rel == 1);
      e_busy  = m_act && rel >= 1;
      e_valid = m_act && (m_nv != 0) && rel >= 3 && (m_iss < m_nv);
      e_done  = m_act && ((m_nv == 0 && rel == 3) || m_done_next);
`ifdef RAND_OPGEN_CHECKSUM_EN
      e_ck = m_ck;
`else
      e_ck = '0;
`endif
      chk("lfsr_resetn", lfsr_resetn, e_lrn);
      if (m_act && rel == 1) chk("lfsr_init", lfsr_init, m_seed);
      chk("busy", busy, e_busy);
      chk("op_valid", op_valid, e_valid);
      chk("done", done, e_done);
      chk("checksum", checksum, e_ck);
      if (e_valid) begin
        chk("op_a", op_a, m_a);
        chk("op_b", op_b, m_b);
      end
      if (!m_act && start) begin
        m_act = 1;
        m_s = cyc;
        m_nv = num_vectors;
        m_seed = seed;
        m_iss = 0;
        m_done_next = 0;
      end else if (e_done) begin
        m_act = 0;
        m_done_next = 0;
      end
      if (e_valid && op_ready) begin
        m_ck = m_ck ^ m_a ^ m_b;
        m_iss++;
        m_a = lfsr_in[31:0];
        m_b = lfsr_in[63:32];
        if (m_iss == m_nv) m_done_next = 1;
      end
    end
  end

  bit          roll = 0;
  logic [31:0] k = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (roll) begin
      k = k + 32'd1;
      lfsr_in = pair(32'h1000_0000 + k, 32'h2000_0000 + k);
    end
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] nv);
    seed = s;
    num_vectors = nv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int hs_cnt);
    bit seen;
    seen = 0;
    hs_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (op_valid && op_ready) hs_cnt++;
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_within_budget", seen, 1);
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] b0;
    int hs;
    resetn = 1'b1;
    start = 1'b0;
    seed = '0;
    num_vectors = '0;
    op_ready = 1'b0;
    lfsr_in = '0;
    #2 resetn = 1'b0;
    tick(); tick(); tick();
    resetn = 1'b1;
    tick(); tick();

    // Basic run: three pairs of (1,2), seed 0xACE1.
    lfsr_in = pair(32'h1, 32'h2);
    op_ready = 1'b1;
    pulse_start(16'hACE1, 16'd3);
    chk("t1_seed_strobe", lfsr_resetn, 0);
    chk("t1_seed_value", lfsr_init, 16'hACE1);
    chk("t1_busy_seed", busy, 1);
    tick();
    chk("t1_warm_strobe", lfsr_resetn, 1);
    chk("t1_warm_valid", op_valid, 0);
    tick();
    chk("t1_first_valid", op_valid, 1);
    chk("t1_first_a", op_a, 32'h1);
    chk("t1_first_b", op_b, 32'h2);
    tick(); tick(); tick();
    chk("t1_done_pulse", done, 1);
    chk("t1_valid_dropped", op_valid, 0);
    tick();
    chk("t1_done_single", done, 0);
    chk("t1_idle_busy", busy, 0);
    tick();

    // Stall with a changing LFSR word; a start pulse mid-run must be ignored.
    roll = 1;
    op_ready = 1'b0;
    pulse_start(16'h1234, 16'd2);
    tick(); tick();
    a0 = op_a;
    b0 = op_b;
    chk("t2_valid_before_stall", op_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_valid", op_valid, 1);
      chk("t2_stall_a", op_a, a0);
      chk("t2_stall_b", op_b, b0);
      if (i == 2) begin
        seed = 16'h5555;
        num_vectors = 16'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    op_ready = 1'b1;
    wait_done(20, hs);
    chk("t2_handshakes", hs, 2);
    tick(); tick();
    roll = 0;

    // Empty run: done three cycles after start, never valid.
    pulse_start(16'hBEEF, 16'd0);
    tick(); tick();
    chk("t3_done_at_3", done, 1);
    chk("t3_no_valid", op_valid, 0);
    tick(); tick();

    // Reset in the middle of a run after one handshake.
    lfsr_in = pair(32'h1, 32'h2);
    pulse_start(16'h0F0F, 16'd5);
    tick(); tick(); tick();
    resetn = 1'b0;
    #1;
    chk("t4_rst_valid", op_valid, 0);
    chk("t4_rst_a", op_a, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_lfsr_resetn", lfsr_resetn, 1);
    chk("t4_rst_lfsr_init", lfsr_init, 0);
    chk("t4_rst_checksum", checksum, 0);
    tick(); tick();
    resetn = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t4_no_done_after_abort", done, 0);

    // Checksum of pairs (1,2) and (4,8).
    lfsr_in = pair(32'h1, 32'h2);
    pulse_start(16'h0001, 16'd2);
    tick();
    tick();
    lfsr_in = pair(32'h4, 32'h8);
    tick();
    tick();
    chk("t5_done", done, 1);
`ifdef RAND_OPGEN_CHECKSUM_EN
    chk("t5_checksum", checksum, 32'hF);
`else
    chk("t5_checksum", checksum, 32'h0);
`endif
    tick(); tick();

    // Maximum count: 65535 pairs, no counter wrap.
    roll = 1;
    pulse_start(16'hFFFF, 16'hFFFF);
    wait_done(70000, hs);
    chk("t6_max_handshakes", hs, 65535);
    tick();
    chk("t6_idle", busy, 0);
    roll = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
